// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multi-cycle processor: fetch/decode/execute/mem/writeback.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.

package params_pkg;
    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 4'hA;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 4'hB;
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT = 4'hC;
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE = 4'hD;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'hE;
endpackage

module multicycle_sequencer #(
    parameter int OPCODE_WIDTH = params_pkg::OPCODE_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    halt_i,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    is_zero_i,
    input  logic                    is_less_i,
    input  logic                    mem_ready_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic                    mem_addr_sel_o,
    output logic                    ir_wr_en_o,
    output logic                    pc_wr_en_o,
    output logic [1:0]              pc_sel_o,
    output logic                    reg_wr_en_o,
    output logic                    wb_sel_o,
    output logic                    busy_o,
    output logic [2:0]              state_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]    retired_cnt_o
`endif
);

    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(params_pkg::OP_LW);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(params_pkg::OP_SW);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(params_pkg::OP_BEQ);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE = OPCODE_WIDTH'(params_pkg::OP_BNE);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT = OPCODE_WIDTH'(params_pkg::OP_BLT);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE = OPCODE_WIDTH'(params_pkg::OP_BGE);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(params_pkg::OP_JMP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t end_state;

    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_blt;
    logic is_bge;
    logic is_jmp;
    logic is_branch;
    logic branch_taken;
    logic instr_end;

    assign is_lw  = (opcode_i == OP_LW);
    assign is_sw  = (opcode_i == OP_SW);
    assign is_beq = (opcode_i == OP_BEQ);
    assign is_bne = (opcode_i == OP_BNE);
    assign is_blt = (opcode_i == OP_BLT);
    assign is_bge = (opcode_i == OP_BGE);
    assign is_jmp = (opcode_i == OP_JMP);

    assign is_branch    = is_beq | is_bne | is_blt | is_bge;
    assign branch_taken = (is_beq & is_zero_i) | (is_bne & ~is_zero_i) |
                          (is_blt & is_less_i) | (is_bge & ~is_less_i);

    // halt_i is only honoured here, so an instruction in flight always completes
    assign end_state = halt_i ? IDLE : FETCH;

    always_comb begin
        instr_end = 1'b0;
        case (state_q)
            EXECUTE:   instr_end = is_branch | is_jmp;
            MEM:       instr_end = mem_ready_i & is_sw;
            WRITEBACK: instr_end = 1'b1;
            default:   instr_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:      state_d = halt_i ? IDLE : FETCH;
            FETCH:     state_d = mem_ready_i ? DECODE : FETCH;
            DECODE:    state_d = EXECUTE;
            EXECUTE: begin
                if (instr_end) begin
                    state_d = end_state;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                if (!mem_ready_i) begin
                    state_d = MEM;
                end else if (is_lw) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = end_state;
                end
            end
            WRITEBACK: state_d = end_state;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_wr_en_o     = 1'b0;
        pc_wr_en_o     = 1'b0;
        pc_sel_o       = 2'b00;
        reg_wr_en_o    = 1'b0;
        wb_sel_o       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_o  = 1'b1;
                ir_wr_en_o = mem_ready_i;
                pc_wr_en_o = mem_ready_i;
            end
            EXECUTE: begin
                if (is_jmp) begin
                    pc_wr_en_o = 1'b1;
                    pc_sel_o   = 2'b10;
                end else if (is_branch && branch_taken) begin
                    pc_wr_en_o = 1'b1;
                    pc_sel_o   = 2'b01;
                end
            end
            MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = is_sw;
            end
            WRITEBACK: begin
                reg_wr_en_o = 1'b1;
                wb_sel_o    = is_lw;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_o   <= '0;
            retired_cnt_o <= '0;
        end else begin
            if (busy_o) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
            end
            if (instr_end) begin
                retired_cnt_o <= retired_cnt_o + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; each scenario task checks its own results.
// Counter checks are compiled in when SEQ_PERF_CNT_EN is defined.

module tb_multicycle_sequencer;
    import params_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    halt_i;
    logic [OPCODE_WIDTH-1:0] opcode_i;
    logic                    is_zero_i;
    logic                    is_less_i;
    logic                    mem_ready_i;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic                    mem_addr_sel_o;
    logic                    ir_wr_en_o;
    logic                    pc_wr_en_o;
    logic [1:0]              pc_sel_o;
    logic                    reg_wr_en_o;
    logic                    wb_sel_o;
    logic                    busy_o;
    logic [2:0]              state_o;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]             cycle_cnt_o;
    logic [31:0]             retired_cnt_o;
`endif

    int checks = 0;
    int passes = 0;

    localparam logic [OPCODE_WIDTH-1:0] OP_ALU = 4'h3;

    multicycle_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .halt_i         (halt_i),
        .opcode_i       (opcode_i),
        .is_zero_i      (is_zero_i),
        .is_less_i      (is_less_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_sel_o (mem_addr_sel_o),
        .ir_wr_en_o     (ir_wr_en_o),
        .pc_wr_en_o     (pc_wr_en_o),
        .pc_sel_o       (pc_sel_o),
        .reg_wr_en_o    (reg_wr_en_o),
        .wb_sel_o       (wb_sel_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt_o    (cycle_cnt_o),
        .retired_cnt_o  (retired_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the DUT parked in IDLE just after a rising edge
    task automatic do_reset;
        rst_ni      = 1'b0;
        halt_i      = 1'b1;
        mem_ready_i = 1'b0;
        opcode_i    = '0;
        is_zero_i   = 1'b0;
        is_less_i   = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i    = OP_ALU;
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o,
             reg_wr_en_o, wb_sel_o, busy_o, state_o} !== 12'd0)
            $display("[TB] FAIL reset_outputs: got %b expected all zero",
                     {mem_req_o, mem_we_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o,
                      reg_wr_en_o, wb_sel_o, busy_o, state_o});
        else passes++;
        tick();
        checks++;
        if (state_o !== 3'd0) $display("[TB] FAIL reset_held_state: got %0d expected 0", state_o);
        else passes++;
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if ({cycle_cnt_o, retired_cnt_o} !== 64'd0)
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt_o, retired_cnt_o);
        else passes++;
`endif
        halt_i = 1'b1;
        rst_ni = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy_o, state_o} !== 4'd0)
            $display("[TB] FAIL idle_halt_hold: got busy=%b state=%0d expected busy=0 state=0", busy_o, state_o);
        else passes++;
    endtask

    task automatic test_alu;
        logic [2:0] exp_st [6];
        int wr_cnt;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        wr_cnt = 0;
        do_reset();
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i    = OP_ALU;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i])
                $display("[TB] FAIL alu_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            else passes++;
            if (reg_wr_en_o === 1'b1) wr_cnt++;
            if (i == 1) begin
                checks++;
                if ({mem_req_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o} !== 6'b101100)
                    $display("[TB] FAIL alu_fetch_outputs: got %b expected 101100",
                             {mem_req_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o});
                else passes++;
            end
            if (i == 4) begin
                checks++;
                if (wb_sel_o !== 1'b0) $display("[TB] FAIL alu_wb_sel: got %b expected 0", wb_sel_o);
                else passes++;
            end
`ifdef SEQ_PERF_CNT_EN
            if (i == 5) begin
                checks++;
                if (cycle_cnt_o !== 32'd4 || retired_cnt_o !== 32'd1)
                    $display("[TB] FAIL alu_counters: got %0d/%0d expected 4/1", cycle_cnt_o, retired_cnt_o);
                else passes++;
            end
`endif
            tick();
        end
        checks++;
        if (wr_cnt !== 1) $display("[TB] FAIL alu_reg_wr_cycles: got %0d expected 1", wr_cnt);
        else passes++;
    endtask

    task automatic test_lw_wait;
        logic [2:0] exp_st [9];
        logic       rdy [9];
        int mem_cnt;
        int we_cnt;
        int lat;
        exp_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        rdy     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        mem_cnt = 0;
        we_cnt  = 0;
        lat     = 0;
        do_reset();
        halt_i   = 1'b0;
        opcode_i = OP_LW;
        for (int i = 0; i < 9; i++) begin
            mem_ready_i = rdy[i];
            #1;
            checks++;
            if (state_o !== exp_st[i])
                $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            else passes++;
            if (mem_req_o === 1'b1 && mem_addr_sel_o === 1'b1) mem_cnt++;
            if (mem_we_o === 1'b1) we_cnt++;
            if (i > 1 && state_o === 3'd1 && lat == 0) lat = i - 1;
            if (i == 7) begin
                checks++;
                if ({reg_wr_en_o, wb_sel_o} !== 2'b11)
                    $display("[TB] FAIL lw_writeback: got %b expected 11", {reg_wr_en_o, wb_sel_o});
                else passes++;
            end
            tick();
        end
        checks++;
        if (mem_cnt !== 3) $display("[TB] FAIL lw_mem_hold: got %0d expected 3", mem_cnt);
        else passes++;
        checks++;
        if (we_cnt !== 0) $display("[TB] FAIL lw_mem_we: got %0d expected 0", we_cnt);
        else passes++;
        checks++;
        if (lat !== 7) $display("[TB] FAIL lw_latency: got %0d expected 7", lat);
        else passes++;
    endtask

    task automatic test_sw;
        logic [2:0] exp_st [6];
        int we_cnt;
        int wr_cnt;
        int lat;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        we_cnt = 0;
        wr_cnt = 0;
        lat    = 0;
        do_reset();
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i    = OP_SW;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i])
                $display("[TB] FAIL sw_state[%0d]: got %0d expected %0d", i, state_o, exp_st[i]);
            else passes++;
            if (mem_we_o === 1'b1) we_cnt++;
            if (reg_wr_en_o === 1'b1) wr_cnt++;
            if (i > 1 && state_o === 3'd1 && lat == 0) lat = i - 1;
            if (i == 4) begin
                checks++;
                if ({mem_req_o, mem_addr_sel_o, mem_we_o} !== 3'b111)
                    $display("[TB] FAIL sw_mem_outputs: got %b expected 111", {mem_req_o, mem_addr_sel_o, mem_we_o});
                else passes++;
            end
            tick();
        end
        checks++;
        if (we_cnt !== 1) $display("[TB] FAIL sw_we_cycles: got %0d expected 1", we_cnt);
        else passes++;
        checks++;
        if (wr_cnt !== 0) $display("[TB] FAIL sw_reg_wr: got %0d expected 0", wr_cnt);
        else passes++;
        checks++;
        if (lat !== 4) $display("[TB] FAIL sw_latency: got %0d expected 4", lat);
        else passes++;
    endtask

    task automatic test_branch;
        logic [OPCODE_WIDTH-1:0] ops [8];
        logic zs [8];
        logic ls [8];
        logic [2:0] exp_pc [8];
        ops    = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BLT, OP_BLT, OP_BGE, OP_BGE};
        zs     = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
        ls     = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
        exp_pc = '{3'b101, 3'b000, 3'b000, 3'b101, 3'b101, 3'b000, 3'b101, 3'b000};
        for (int k = 0; k < 8; k++) begin
            do_reset();
            halt_i      = 1'b0;
            mem_ready_i = 1'b1;
            opcode_i    = ops[k];
            is_zero_i   = zs[k];
            is_less_i   = ls[k];
            tick();
            tick();
            tick();
            checks++;
            if (state_o !== 3'd3 || {pc_wr_en_o, pc_sel_o} !== exp_pc[k])
                $display("[TB] FAIL branch_exec[%0d]: got state=%0d pc=%b expected state=3 pc=%b",
                         k, state_o, {pc_wr_en_o, pc_sel_o}, exp_pc[k]);
            else passes++;
            tick();
            checks++;
            if (state_o !== 3'd1)
                $display("[TB] FAIL branch_next[%0d]: got %0d expected 1", k, state_o);
            else passes++;
        end
    endtask

    task automatic test_jmp_halt;
        do_reset();
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i    = OP_JMP;
        tick();
        tick();
        halt_i = 1'b1;
        tick();
        checks++;
        if (state_o !== 3'd3 || {pc_wr_en_o, pc_sel_o} !== 3'b110)
            $display("[TB] FAIL jmp_exec: got state=%0d pc=%b expected state=3 pc=110",
                     state_o, {pc_wr_en_o, pc_sel_o});
        else passes++;
        tick();
        checks++;
        if ({busy_o, state_o} !== 4'd0)
            $display("[TB] FAIL jmp_halt_idle: got busy=%b state=%0d expected busy=0 state=0", busy_o, state_o);
        else passes++;
        tick();
        checks++;
        if (state_o !== 3'd0) $display("[TB] FAIL jmp_idle_hold: got %0d expected 0", state_o);
        else passes++;
        halt_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, state_o} !== 4'b1001)
            $display("[TB] FAIL jmp_resume: got busy=%b state=%0d expected busy=1 state=1", busy_o, state_o);
        else passes++;
    endtask

    task automatic test_reset_mid_mem;
        do_reset();
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i    = OP_SW;
        tick();
        tick();
        mem_ready_i = 1'b0;
        tick();
        tick();
        checks++;
        if (state_o !== 3'd4 || {mem_req_o, mem_addr_sel_o, mem_we_o} !== 3'b111)
            $display("[TB] FAIL mid_mem_wait: got state=%0d mem=%b expected state=4 mem=111",
                     state_o, {mem_req_o, mem_addr_sel_o, mem_we_o});
        else passes++;
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (cycle_cnt_o !== 32'd3 || retired_cnt_o !== 32'd0)
            $display("[TB] FAIL mid_mem_counters: got %0d/%0d expected 3/0", cycle_cnt_o, retired_cnt_o);
        else passes++;
`endif
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o,
             reg_wr_en_o, wb_sel_o, busy_o, state_o} !== 12'd0)
            $display("[TB] FAIL mid_mem_reset: got %b expected all zero",
                     {mem_req_o, mem_we_o, mem_addr_sel_o, ir_wr_en_o, pc_wr_en_o, pc_sel_o,
                      reg_wr_en_o, wb_sel_o, busy_o, state_o});
        else passes++;
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if ({cycle_cnt_o, retired_cnt_o} !== 64'd0)
            $display("[TB] FAIL mid_mem_reset_counters: got %0d/%0d expected 0/0", cycle_cnt_o, retired_cnt_o);
        else passes++;
`endif
        halt_i = 1'b1;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        halt_i      = 1'b1;
        opcode_i    = '0;
        is_zero_i   = 1'b0;
        is_less_i   = 1'b0;
        mem_ready_i = 1'b0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jmp_halt();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Main FSM of the multi-cycle processor.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the write enables, mux selects and memory request for the shared datapath and the single unified memory port.
- Consumes the opcode and the ALU flags (zero, less) and decides branch and jump resolution.

Parameters:
- OPCODE_WIDTH, default params_pkg::OPCODE_WIDTH, width of the opcode field.
- CNT_WIDTH, default 32, width of the performance counters (optional feature only).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- halt_i  input  1  when 1, the FSM parks in IDLE at the next instruction boundary.
- opcode_i  input  OPCODE_WIDTH  opcode from the instruction register; valid from DECODE onward.
- is_zero_i  input  1  ALU zero flag; valid in EXECUTE.
- is_less_i  input  1  ALU less-than flag; valid in EXECUTE.
- mem_ready_i  input  1  memory accepted or completed the current request this cycle.
- mem_req_o  output  1  memory request, held until mem_ready_i.
- mem_we_o  output  1  memory write (SW).
- mem_addr_sel_o  output  1  memory address select: 0 = PC, 1 = ALU result.
- ir_wr_en_o  output  1  load the instruction register.
- pc_wr_en_o  output  1  PC write enable.
- pc_sel_o  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- reg_wr_en_o  output  1  register file write enable.
- wb_sel_o  output  1  writeback source: 0 = ALU, 1 = memory data.
- busy_o  output  1  1 in every state except IDLE.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEM = 4, WRITEBACK = 5. Encodings 6 and 7 are unreachable and recover to IDLE.
- Reset (rst_ni low, asynchronous): state = IDLE; every output 0; pc_sel_o = 00.
- Output timing: outputs are decoded from the current state, plus mem_ready_i where stated. Any output not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Goes to FETCH when halt_i == 0, otherwise stays.
- FETCH:
  - mem_req_o = 1, mem_addr_sel_o = 0.
  - Waits any number of cycles for mem_ready_i.
  - In the cycle mem_ready_i == 1: ir_wr_en_o = 1, pc_wr_en_o = 1, pc_sel_o = 00; next state DECODE.
- DECODE:
  - One cycle, no side effects; next state EXECUTE.
- EXECUTE (one cycle):
  - BEQ, BNE, BLT, BGE: branch taken when (BEQ & zero) | (BNE & ~zero) | (BLT & less) | (BGE & ~less). If taken, pc_wr_en_o = 1 and pc_sel_o = 01. Instruction ends.
  - JMP: pc_wr_en_o = 1, pc_sel_o = 10. Instruction ends.
  - LW, SW: next state MEM.
  - Any other opcode (ALU class): next state WRITEBACK.
- MEM:
  - mem_req_o = 1, mem_addr_sel_o = 1, mem_we_o = (opcode == SW).
  - Held until mem_ready_i.
  - On mem_ready_i: LW goes to WRITEBACK; SW ends.
- WRITEBACK:
  - reg_wr_en_o = 1, wb_sel_o = (opcode == LW).
  - Instruction ends.
- Instruction end: next state is IDLE if halt_i == 1 in that cycle, else FETCH.
- Halt timing: halt_i never aborts an instruction in flight; it is sampled only at IDLE and at instruction end.
- Minimum latency, counted from FETCH entry with mem_ready_i always 1:
  - branch / jump: 3 cycles
  - SW: 4 cycles
  - ALU: 4 cycles
  - LW: 5 cycles
- Each cycle that mem_ready_i is low in FETCH or MEM adds exactly one cycle.
- Handshake rules:
  - mem_req_o, mem_we_o and mem_addr_sel_o stay stable while waiting.
  - mem_ready_i is ignored outside FETCH and MEM.
- Reset mid-instruction: immediate return to IDLE with all outputs 0. No partial register or PC write occurs after reset asserts.
- Sequencing invariants:
  - reg_wr_en_o and mem_we_o are never 1 in the same cycle.
  - pc_wr_en_o is at most one cycle wide per FETCH and per EXECUTE.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined, adds two outputs, cycle_cnt_o [CNT_WIDTH] and retired_cnt_o [CNT_WIDTH]:
  - cycle_cnt_o increments every cycle busy_o == 1.
  - retired_cnt_o increments on every instruction-end cycle.
  - Both wrap modulo 2^CNT_WIDTH and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ALU opcode with halt_i = 0 and mem_ready_i = 1 -> states 0,1,2,3,5,1; reg_wr_en_o = 1 in one cycle; wb_sel_o = 0.
- LW with mem_ready_i low for 2 cycles in MEM -> mem_req_o = 1 and mem_addr_sel_o = 1 held 3 cycles; then WRITEBACK with wb_sel_o = 1; total latency 7 cycles.
- SW -> mem_we_o = 1 only in MEM; reg_wr_en_o never 1; returns to FETCH after 4 cycles.
- BEQ with is_zero_i = 1 -> pc_wr_en_o = 1, pc_sel_o = 01 in EXECUTE. BNE with is_zero_i = 1 -> no PC write in EXECUTE. BGE with is_less_i = 0 -> taken.
- JMP with halt_i = 1 at EXECUTE -> pc_sel_o = 10, then IDLE with busy_o = 0. Deasserting halt_i -> FETCH on the next cycle.
- rst_ni pulsed low during MEM of an SW -> all outputs 0 immediately, state_o = 0. With SEQ_PERF_CNT_EN defined, both counters read 0.
